// File: rtl/tiny8_control.sv
// tiny8 multicycle controller: fetch/decode/exec/mem sequencing
// and datapath load, mux and memory strobe generation.
package tiny8_pkg;

    typedef enum logic [3:0] {
        op_addi = 4'h0,
        op_inc  = 4'h1,
        op_acc  = 4'h2,
        op_br   = 4'h3,
        op_ld   = 4'h4,
        op_st   = 4'h5,
        op_halt = 4'h6
    } tiny8_opcode;

    typedef enum logic [1:0] {
        alu_add = 2'b00,
        alu_sub = 2'b01,
        alu_and = 2'b10,
        alu_or  = 2'b11
    } tiny8_aluop;

endpackage

module tiny8_control
    import tiny8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  tiny8_opcode opcode,
    input  logic        mem_resp,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_acc,
    output logic        load_rs,
    output logic        load_rd,
    output tiny8_aluop  aluop,
    output logic        pcmux_sel,
    output logic        alumux1_sel,
    output logic        alumux2_sel,
    output logic        regfilemux_sel,
    output logic [1:0]  addrmux_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_acc       = 1'b0;
        load_rs        = 1'b0;
        load_rd        = 1'b0;
        aluop          = alu_add;
        pcmux_sel      = 1'b0;
        alumux1_sel    = 1'b0;
        alumux2_sel    = 1'b0;
        regfilemux_sel = 1'b0;
        addrmux_sel    = 2'b00;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        halted         = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                addrmux_sel = 2'b00;
                mem_read    = 1'b1;
                if (mem_resp) begin
                    load_ir   = 1'b1;
                    load_pc   = 1'b1;
                    pcmux_sel = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    op_ld, op_st: state_d = S_MEM;
                    op_halt:      state_d = S_HALT;
                    default:      state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    op_addi: begin
                        alumux1_sel    = 1'b1;
                        alumux2_sel    = 1'b1;
                        regfilemux_sel = 1'b0;
                        load_rd        = 1'b1;
                    end
                    op_inc: begin
                        load_rs = 1'b1;
                    end
                    op_acc: begin
                        load_acc = 1'b1;
                    end
                    op_br: begin
                        pcmux_sel = 1'b1;
                        load_pc   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Anything that reached MEM but is not a store is a load.
                if (opcode == op_st) begin
                    addrmux_sel = 2'b10;
                    mem_write   = 1'b1;
                end else begin
                    addrmux_sel = 2'b01;
                    mem_read    = 1'b1;
                    if (mem_resp) begin
                        regfilemux_sel = 1'b1;
                        load_rd        = 1'b1;
                    end
                end
                if (mem_resp) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset wins over every state-derived output in the same cycle.
        if (!rst_n) begin
            state_d        = S_FETCH;
            load_pc        = 1'b0;
            load_ir        = 1'b0;
            load_acc       = 1'b0;
            load_rs        = 1'b0;
            load_rd        = 1'b0;
            aluop          = alu_add;
            pcmux_sel      = 1'b0;
            alumux1_sel    = 1'b0;
            alumux2_sel    = 1'b0;
            regfilemux_sel = 1'b0;
            addrmux_sel    = 2'b00;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            halted         = 1'b0;
        end
    end

endmodule

// File: tb/tb_tiny8_control.sv
// Randomized bench for tiny8_control against a per-instruction
// expected-cycle model.
module tb_tiny8_control;
    import tiny8_pkg::*;

    typedef struct packed {
        logic       load_pc;
        logic       load_ir;
        logic       load_acc;
        logic       load_rs;
        logic       load_rd;
        logic [1:0] aluop;
        logic       pcmux_sel;
        logic       alumux1_sel;
        logic       alumux2_sel;
        logic       regfilemux_sel;
        logic [1:0] addrmux_sel;
        logic       mem_read;
        logic       mem_write;
        logic       halted;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    tiny8_opcode opcode;
    logic        mem_resp;
    logic        load_pc, load_ir, load_acc, load_rs, load_rd;
    tiny8_aluop  aluop;
    logic        pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel;
    logic [1:0]  addrmux_sel;
    logic        mem_read, mem_write, halted;

    outs_t got;
    int    n_chk  = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    tiny8_control dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .mem_resp       (mem_resp),
        .load_pc        (load_pc),
        .load_ir        (load_ir),
        .load_acc       (load_acc),
        .load_rs        (load_rs),
        .load_rd        (load_rd),
        .aluop          (aluop),
        .pcmux_sel      (pcmux_sel),
        .alumux1_sel    (alumux1_sel),
        .alumux2_sel    (alumux2_sel),
        .regfilemux_sel (regfilemux_sel),
        .addrmux_sel    (addrmux_sel),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .halted         (halted)
    );

    assign got = outs_t'({load_pc, load_ir, load_acc, load_rs, load_rd,
                          aluop, pcmux_sel, alumux1_sel, alumux2_sel,
                          regfilemux_sel, addrmux_sel, mem_read,
                          mem_write, halted});

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Drive just after the rising edge, sample on the falling edge.
    task automatic step(tiny8_opcode opc, logic resp, logic rn,
                        outs_t exp, string tag);
        opcode   = opc;
        mem_resp = resp;
        rst_n    = rn;
        @(negedge clk);
        check(tag, got, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t quiet();
        outs_t e;
        e       = '0;
        e.aluop = alu_add;
        return e;
    endfunction

    function automatic tiny8_opcode rnd_op();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        return tiny8_opcode'(v);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Fetch ignores opcode, so junk opcodes are driven there.
    task automatic run_fetch(int fw);
        outs_t e;
        for (int i = 0; i < fw; i++) begin
            e          = quiet();
            e.mem_read = 1'b1;
            step(rnd_op(), 1'b0, 1'b1, e, "fetch_wait");
        end
        e          = quiet();
        e.mem_read = 1'b1;
        e.load_ir  = 1'b1;
        e.load_pc  = 1'b1;
        step(rnd_op(), 1'b1, 1'b1, e, "fetch_resp");
    endtask

    task automatic run_instr(tiny8_opcode opc, int fw, int mw, int hc);
        outs_t e;
        run_fetch(fw);
        step(opc, rnd_bit(), 1'b1, quiet(), "decode");
        if (opc == op_ld || opc == op_st) begin
            for (int i = 0; i <= mw; i++) begin
                e = quiet();
                if (opc == op_st) begin
                    e.addrmux_sel = 2'b10;
                    e.mem_write   = 1'b1;
                end else begin
                    e.addrmux_sel = 2'b01;
                    e.mem_read    = 1'b1;
                    if (i == mw) begin
                        e.load_rd        = 1'b1;
                        e.regfilemux_sel = 1'b1;
                    end
                end
                step(opc, (i == mw), 1'b1, e,
                     (opc == op_st) ? "mem_st" : "mem_ld");
            end
        end else if (opc == op_halt) begin
            for (int i = 0; i < hc; i++) begin
                e        = quiet();
                e.halted = 1'b1;
                step(opc, 1'(i), 1'b1, e, "halt");
            end
            step(opc, 1'b1, 1'b0, quiet(), "halt_rst");
        end else begin
            e = quiet();
            if (opc == op_addi) begin
                e.alumux1_sel = 1'b1;
                e.alumux2_sel = 1'b1;
                e.load_rd     = 1'b1;
            end else if (opc == op_inc) begin
                e.load_rs = 1'b1;
            end else if (opc == op_acc) begin
                e.load_acc = 1'b1;
            end else if (opc == op_br) begin
                e.pcmux_sel = 1'b1;
                e.load_pc   = 1'b1;
            end
            step(opc, rnd_bit(), 1'b1, e, "exec");
        end
    endtask

    initial begin
        outs_t e;
        rst_n    = 1'b0;
        opcode   = op_addi;
        mem_resp = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(rnd_op(), rnd_bit(), 1'b0, quiet(), "reset");
        end

        run_instr(op_addi, 0, 0, 0);
        run_instr(op_ld, 0, 2, 0);
        run_instr(op_st, 1, 2, 0);
        run_instr(op_br, 0, 0, 0);
        run_instr(op_inc, 2, 0, 0);
        run_instr(op_acc, 0, 0, 0);
        run_instr(tiny8_opcode'(4'hB), 0, 0, 0);
        run_instr(op_ld, 0, 0, 0);
        run_instr(op_halt, 0, 0, 20);

        // Reset in the second wait cycle of a load, with a stray strobe.
        run_fetch(0);
        step(op_ld, 1'b0, 1'b1, quiet(), "decode");
        e             = quiet();
        e.addrmux_sel = 2'b01;
        e.mem_read    = 1'b1;
        step(op_ld, 1'b0, 1'b1, e, "ld_wait");
        step(op_ld, 1'b1, 1'b0, quiet(), "ld_rst");
        run_instr(op_addi, 0, 0, 0);

        // Reset during a fetch wait drops the read at once.
        e          = quiet();
        e.mem_read = 1'b1;
        step(rnd_op(), 1'b0, 1'b1, e, "fetch_wait");
        step(rnd_op(), 1'b1, 1'b0, quiet(), "fetch_rst");

        for (int n = 0; n < 200; n++) begin
            run_instr(rnd_op(), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
